// File: rtl/umi_adder_host.sv
// -----------------------------------------------------------------------------
// umi_adder_host
//
// Host-side UMI initiator for the adder register device. A start pulse runs
// one fixed transaction:
//   1. write operand A to DEVBASE + 0x00, wait for the write ack
//   2. write operand B to DEVBASE + 0x08, wait for the write ack
//   3. read the sum from DEVBASE + 0x10, wait for the read response
// and then pulses done together with the sum and an error status.
// Only one request is outstanding at any time.
//
// Optional build macro:
//   UMI_ADDER_HOST_TIMEOUT_EN - adds a 16-bit response-wait timeout. When a
//   WT_* wait would take the count to 16'hFFFF, the transaction ends with
//   error=1 and the remaining steps are skipped. When undefined, the WT_*
//   states wait indefinitely.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   start                one-cycle start pulse, only honoured when idle
//   op_a, op_b           operands, sampled on an accepted start
//   busy                 high whenever the FSM is not in IDLE
//   done                 one-cycle completion pulse
//   sum                  read-back sum, held until the next accepted start
//   error                sticky status: bad response opcode (or timeout)
//   uhost_req_*          request channel (valid/ready, cmd, dst, src, data)
//   uhost_resp_*         response channel (valid/ready, cmd, dst, src, data)
// -----------------------------------------------------------------------------
module umi_adder_host #(
  parameter int unsigned     CW      = 32,
  parameter int unsigned     AW      = 64,
  parameter int unsigned     DW      = 32,
  parameter logic [AW-1:0]   DEVBASE = '0,
  parameter logic [AW-1:0]   SRCADDR = '0
) (
  input  logic          clk,
  input  logic          nreset,
  // local control
  input  logic          start,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic          error,
  // request channel
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  // response channel
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready
);

  // ---------------------------------------------------------------------------
  // Command encoding
  // ---------------------------------------------------------------------------
  localparam logic [4:0] OP_REQ_READ   = 5'h01;
  localparam logic [4:0] OP_REQ_WRITE  = 5'h03;
  localparam logic [4:0] OP_RESP_READ  = 5'h02;
  localparam logic [4:0] OP_RESP_WRITE = 5'h04;

  // Register addresses; the addition wraps modulo 2^AW.
  localparam logic [AW-1:0] ADDR_A = DEVBASE;
  localparam logic [AW-1:0] ADDR_B = DEVBASE + AW'(8);
  localparam logic [AW-1:0] ADDR_C = DEVBASE + AW'(16);

  // Build a full command word: opcode, size=2 (4 bytes), len=0, rest zero.
  function automatic logic [CW-1:0] mk_cmd(input logic [4:0] opcode);
    logic [CW-1:0] c;
    c       = '0;
    c[4:0]  = opcode;
    c[7:5]  = 3'd2;
    c[15:8] = 8'd0;
    return c;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WT_A,
    S_WR_B,
    S_WT_B,
    S_RD_C,
    S_WT_C,
    S_FIN
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_req_valid;
  logic [CW-1:0]   r_req_cmd;
  logic [AW-1:0]   r_req_dstaddr;
  logic [DW-1:0]   r_req_data;
  logic            r_resp_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic [DW-1:0]   r_sum;
  logic [DW-1:0]   r_op_b;

  logic            w_req_fire;
  logic            w_resp_fire;
  logic            w_wait;
  logic            w_tmo;
  logic [4:0]      w_resp_op;

  assign w_req_fire  = r_req_valid  & uhost_req_ready;
  assign w_resp_fire = r_resp_ready & uhost_resp_valid;
  assign w_wait      = (r_state == S_WT_A) || (r_state == S_WT_B) ||
                       (r_state == S_WT_C);
  assign w_resp_op   = uhost_resp_cmd[4:0];

  // Response routing fields and the non-opcode command bits are not checked.
  logic w_unused;
  assign w_unused = ^{uhost_resp_dstaddr, uhost_resp_srcaddr,
                      uhost_resp_cmd[CW-1:5]};

  // ---------------------------------------------------------------------------
  // Optional response-wait timeout
  // ---------------------------------------------------------------------------
`ifdef UMI_ADDER_HOST_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // The count is zero outside the WT_* states, so it restarts on every entry.
  // In the k-th wait cycle it holds k-1; the timeout fires in the cycle whose
  // increment would bring it to 16'hFFFF. A response in that same cycle wins.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_tmo_cnt <= '0;
    end else if (!w_wait || w_resp_fire) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_tmo = w_wait && !w_resp_fire && (r_tmo_cnt == 16'hFFFE);
`else
  assign w_tmo = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top covers every path through the
  // case, so no latch is inferred for w_state_nxt.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start)       w_state_nxt = S_WR_A;
      S_WR_A: if (w_req_fire)  w_state_nxt = S_WT_A;
      S_WT_A: begin
        if (w_resp_fire)       w_state_nxt = S_WR_B;
        else if (w_tmo)        w_state_nxt = S_FIN;
      end
      S_WR_B: if (w_req_fire)  w_state_nxt = S_WT_B;
      S_WT_B: begin
        if (w_resp_fire)       w_state_nxt = S_RD_C;
        else if (w_tmo)        w_state_nxt = S_FIN;
      end
      S_RD_C: if (w_req_fire)  w_state_nxt = S_WT_C;
      S_WT_C: begin
        if (w_resp_fire)       w_state_nxt = S_FIN;
        else if (w_tmo)        w_state_nxt = S_FIN;
      end
      S_FIN:                   w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // Handshake and status flags are decoded from the next state so they are
  // registered yet line up with the state they belong to. The request payload
  // is loaded only on the transition into a request state, which keeps it
  // stable for as long as valid waits for ready.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_req_valid   <= 1'b0;
      r_req_cmd     <= '0;
      r_req_dstaddr <= '0;
      r_req_data    <= '0;
      r_resp_ready  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_sum         <= '0;
      r_op_b        <= '0;
    end else begin
      r_req_valid  <= (w_state_nxt == S_WR_A) || (w_state_nxt == S_WR_B) ||
                      (w_state_nxt == S_RD_C);
      r_resp_ready <= (w_state_nxt == S_WT_A) || (w_state_nxt == S_WT_B) ||
                      (w_state_nxt == S_WT_C);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_FIN);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Operand A goes straight into the request data register.
            r_op_b        <= op_b;
            r_error       <= 1'b0;
            r_req_cmd     <= mk_cmd(OP_REQ_WRITE);
            r_req_dstaddr <= ADDR_A;
            r_req_data    <= op_a;
          end
        end
        S_WT_A: begin
          if (w_resp_fire) begin
            if (w_resp_op != OP_RESP_WRITE) r_error <= 1'b1;
            r_req_cmd     <= mk_cmd(OP_REQ_WRITE);
            r_req_dstaddr <= ADDR_B;
            r_req_data    <= r_op_b;
          end else if (w_tmo) begin
            r_error <= 1'b1;
          end
        end
        S_WT_B: begin
          if (w_resp_fire) begin
            if (w_resp_op != OP_RESP_WRITE) r_error <= 1'b1;
            r_req_cmd     <= mk_cmd(OP_REQ_READ);
            r_req_dstaddr <= ADDR_C;
            r_req_data    <= '0;
          end else if (w_tmo) begin
            r_error <= 1'b1;
          end
        end
        S_WT_C: begin
          if (w_resp_fire) begin
            if (w_resp_op != OP_RESP_READ) r_error <= 1'b1;
            r_sum <= uhost_resp_data;
          end else if (w_tmo) begin
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign busy              = r_busy;
  assign done              = r_done;
  assign sum               = r_sum;
  assign error             = r_error;
  assign uhost_req_valid   = r_req_valid;
  assign uhost_req_cmd     = r_req_cmd;
  assign uhost_req_dstaddr = r_req_dstaddr;
  assign uhost_req_srcaddr = SRCADDR;
  assign uhost_req_data    = r_req_data;
  assign uhost_resp_ready  = r_resp_ready;

endmodule

// File: tb/tb_umi_adder_host.sv
// -----------------------------------------------------------------------------
// tb_umi_adder_host
//
// Scoreboard bench for umi_adder_host. Stimulus pushes the expected requests
// and the expected completion into queues; a device process models the adder
// register device and checks each accepted request, and a done monitor checks
// each completion. The DUT uses a device base near the top of the address
// space so that the register offsets wrap.
// -----------------------------------------------------------------------------
module tb_umi_adder_host;

  localparam int unsigned CW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;
  localparam logic [63:0] DEVBASE = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] SRCADDR = 64'h0000_0000_1234_5678;

  // Hand-computed addresses (wrapping) and full command words.
  localparam logic [63:0] ADDR_A = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] ADDR_B = 64'h0000_0000_0000_0000;
  localparam logic [63:0] ADDR_C = 64'h0000_0000_0000_0008;
  localparam logic [31:0] CMD_WR = 32'h0000_0043;
  localparam logic [31:0] CMD_RD = 32'h0000_0041;
  // Responses carry junk in the upper bits; only [4:0] matters.
  localparam logic [31:0] RSP_WR = 32'hFFFF_FFE4;
  localparam logic [31:0] RSP_RD = 32'hFFFF_FFE2;

  typedef struct {
    logic [31:0] cmd;
    logic [63:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [31:0] sum;
    logic        err;
  } done_t;

  logic          clk;
  logic          nreset;
  logic          start;
  logic [DW-1:0] op_a, op_b;
  logic          busy, done, error;
  logic [DW-1:0] sum;
  logic          uhost_req_valid, uhost_req_ready;
  logic [CW-1:0] uhost_req_cmd;
  logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
  logic [DW-1:0] uhost_req_data;
  logic          uhost_resp_valid, uhost_resp_ready;
  logic [CW-1:0] uhost_resp_cmd;
  logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
  logic [DW-1:0] uhost_resp_data;

  umi_adder_host #(
    .CW(CW), .AW(AW), .DW(DW), .DEVBASE(DEVBASE), .SRCADDR(SRCADDR)
  ) dut (
    .clk               (clk),
    .nreset            (nreset),
    .start             (start),
    .op_a              (op_a),
    .op_b              (op_b),
    .busy              (busy),
    .done              (done),
    .sum               (sum),
    .error             (error),
    .uhost_req_valid   (uhost_req_valid),
    .uhost_req_cmd     (uhost_req_cmd),
    .uhost_req_dstaddr (uhost_req_dstaddr),
    .uhost_req_srcaddr (uhost_req_srcaddr),
    .uhost_req_data    (uhost_req_data),
    .uhost_req_ready   (uhost_req_ready),
    .uhost_resp_valid  (uhost_resp_valid),
    .uhost_resp_cmd    (uhost_resp_cmd),
    .uhost_resp_dstaddr(uhost_resp_dstaddr),
    .uhost_resp_srcaddr(uhost_resp_srcaddr),
    .uhost_resp_data   (uhost_resp_data),
    .uhost_resp_ready  (uhost_resp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int    n_tests = 0;
  int    n_fail  = 0;
  req_t  exp_req_q[$];
  done_t exp_done_q[$];

  // Device controls (written by the main sequence only).
  int    ready_stall  = 0;   // cycles of req_ready=0 per request
  int    bad_ack_at   = -1;  // request number whose ack uses the wrong opcode
  bit    no_read_resp = 1'b0;
  int    clr_req      = 0;   // bump to make the device drop a pending response

  // Device state (written by the device process only).
  int    n_req = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [31:0] c, input logic [63:0] a,
                          input logic [31:0] d);
    req_t r;
    r.cmd  = c;
    r.addr = a;
    r.data = d;
    exp_req_q.push_back(r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_error"},      error, 0);
    check({tag, "_sum"},        sum, 0);
    check({tag, "_req_valid"},  uhost_req_valid, 0);
    check({tag, "_resp_ready"}, uhost_resp_ready, 0);
    check({tag, "_req_cmd"},    uhost_req_cmd, 0);
    check({tag, "_req_dst"},    uhost_req_dstaddr, 0);
    check({tag, "_req_data"},   uhost_req_data, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Device model + request monitor
  // ---------------------------------------------------------------------------
  initial begin : device
    logic        rq, rs, hold_valid;
    req_t        held, got, ex;
    logic [31:0] reg_a, reg_b;
    int          stall_cnt, clr_seen;
    hold_valid = 1'b0;
    reg_a = '0;
    reg_b = '0;
    stall_cnt = 0;
    clr_seen = 0;
    uhost_req_ready    = 1'b1;
    uhost_resp_valid   = 1'b0;
    uhost_resp_cmd     = '0;
    uhost_resp_dstaddr = '0;
    uhost_resp_srcaddr = '0;
    uhost_resp_data    = '0;
    forever begin
      @(negedge clk);
      rq = uhost_req_valid && uhost_req_ready;
      rs = uhost_resp_valid && uhost_resp_ready;
      got.cmd  = uhost_req_cmd;
      got.addr = uhost_req_dstaddr;
      got.data = uhost_req_data;
      if (uhost_req_valid && (hold_valid || !uhost_req_ready)) begin
        if (hold_valid) begin
          check("req_stable_cmd",  got.cmd,  held.cmd);
          check("req_stable_addr", got.addr, held.addr);
          check("req_stable_data", got.data, held.data);
        end
        held = got;
        hold_valid = 1'b1;
      end
      if (uhost_req_valid && !uhost_req_ready) stall_cnt++;
      if (rq) begin
        n_req++;
        hold_valid = 1'b0;
        stall_cnt = 0;
        check("req_expected", exp_req_q.size() > 0, 1);
        if (exp_req_q.size() > 0) begin
          ex = exp_req_q.pop_front();
          check("req_cmd",  got.cmd,  ex.cmd);
          check("req_dst",  got.addr, ex.addr);
          check("req_src",  uhost_req_srcaddr, SRCADDR);
          check("req_data", got.data, ex.data);
        end
        if (got.cmd[4:0] == 5'h03) begin
          if (got.addr == ADDR_A) reg_a = got.data;
          if (got.addr == ADDR_B) reg_b = got.data;
        end
      end
      @(posedge clk);
      #1;
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        uhost_resp_valid = 1'b0;
        hold_valid = 1'b0;
        stall_cnt = 0;
      end else begin
        if (rs) uhost_resp_valid = 1'b0;
        if (rq) begin
          if (got.cmd[4:0] == 5'h03) begin
            uhost_resp_valid = 1'b1;
            uhost_resp_cmd   = (n_req == bad_ack_at) ? RSP_RD : RSP_WR;
            uhost_resp_data  = '0;
          end else if (!no_read_resp) begin
            uhost_resp_valid = 1'b1;
            uhost_resp_cmd   = RSP_RD;
            uhost_resp_data  = reg_a + reg_b;
          end
        end
      end
      uhost_req_ready = (stall_cnt >= ready_stall);
    end
  end

  // ---------------------------------------------------------------------------
  // Done monitor
  // ---------------------------------------------------------------------------
  initial begin : done_mon
    done_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_expected", exp_done_q.size() > 0, 1);
        if (exp_done_q.size() > 0) begin
          e = exp_done_q.pop_front();
          check("done_sum",   sum,   e.sum);
          check("done_error", error, e.err);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One complete transaction. exp_lat=0 skips the latency check; restart_at>0
  // pulses start (with different operands) at that cycle of the transaction.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_sum, input logic exp_err,
                        input int exp_lat, input int restart_at,
                        input int bound);
    done_t d;
    int    cnt;
    bit    got;
    push_req(CMD_WR, ADDR_A, a);
    push_req(CMD_WR, ADDR_B, b);
    push_req(CMD_RD, ADDR_C, 32'h0);
    d.sum = exp_sum;
    d.err = exp_err;
    exp_done_q.push_back(d);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    cnt   = 0;
    got   = 1'b0;
    while (!got && cnt < bound) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) start = 1'b0;
      if (restart_at > 0 && cnt == restart_at) begin
        start = 1'b1;
        op_a  = 32'd9;
        op_b  = 32'd9;
      end
      if (restart_at > 0 && cnt == restart_at + 1) start = 1'b0;
      check("busy_during_op", busy, 1);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    if (exp_lat > 0) check("latency", cnt, exp_lat);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("req_q_drained", exp_req_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int n0;
    nreset = 1'b0;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Basic: 5 + 7, zero-wait device, 7-cycle latency.
    run_op(32'd5, 32'd7, 32'd12, 1'b0, 7, 0, 50);

    // Back-pressure: 3 stall cycles per request.
    ready_stall = 3;
    n0 = n_req;
    run_op(32'h1000_0000, 32'h2345_6789, 32'h3345_6789, 1'b0, 0, 0, 100);
    check("bp_req_count", n_req - n0, 3);
    ready_stall = 0;

    // Sum wraps at DW bits.
    run_op(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 7, 0, 50);

    // Wrong ack opcode on the first write, then a clean transaction.
    bad_ack_at = n_req + 1;
    run_op(32'd3, 32'd4, 32'd7, 1'b1, 7, 0, 50);
    bad_ack_at = -1;
    run_op(32'd1, 32'd1, 32'd2, 1'b0, 7, 0, 50);

    // start while busy is ignored.
    run_op(32'd20, 32'd22, 32'd42, 1'b0, 7, 3, 50);

    // Reset while waiting for the second ack.
    push_req(CMD_WR, ADDR_A, 32'd50);
    push_req(CMD_WR, ADDR_B, 32'd60);
    op_a  = 32'd50;
    op_b  = 32'd60;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wt_b_resp_ready", uhost_resp_ready, 1);
    check("wt_b_busy", busy, 1);
    #1;
    nreset = 1'b0;
    #1;
    check_zero("midreset");
    clr_req++;
    check("midreset_req_q", exp_req_q.size(), 0);
    @(negedge clk);
    nreset = 1'b1;
    run_op(32'd100, 32'd200, 32'd300, 1'b0, 7, 0, 50);

`ifdef UMI_ADDER_HOST_TIMEOUT_EN
    // Read never answered: error, sum unchanged, 65535 cycles in WT_C.
    no_read_resp = 1'b1;
    run_op(32'd8, 32'd8, 32'd300, 1'b1, 65541, 0, 70000);
    no_read_resp = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/umi_adder_host.md
Name: umi_adder_host

Overview:
- UMI host-side initiator that drives the adder register device.
- On `start`, it writes operand A to offset 0x00 and operand B to offset 0x08, then reads the sum from offset 0x10.
- Each write is acknowledged.
- It returns the sum and a status, and sits between a local controller or test sequencer and the uhost request/response ports of a clink.

Parameters:
- CW, 32, UMI command width.
- AW, 64, UMI address width.
- DW, 32, UMI data width (operand and sum width).
- DEVBASE, 64'h0, device base address; register offsets are added to this.
- SRCADDR, 64'h0, srcaddr placed in every request, used by the device for response routing.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a transaction, ignored unless idle
- op_a  in  DW  operand A, sampled on accepted start
- op_b  in  DW  operand B, sampled on accepted start
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at completion
- sum  out  DW  read-back sum, valid from done until next accepted start
- error  out  1  status accompanying done; 1 = unexpected response opcode (or timeout)
- uhost_req_valid  out  1  request valid
- uhost_req_cmd  out  CW  request command
- uhost_req_dstaddr  out  AW  request destination address
- uhost_req_srcaddr  out  AW  request source address (= SRCADDR)
- uhost_req_data  out  DW  request write data
- uhost_req_ready  in  1  request accepted when valid & ready
- uhost_resp_valid  in  1  response valid
- uhost_resp_cmd  in  CW  response command
- uhost_resp_dstaddr  in  AW  response destination address (unused, ignored)
- uhost_resp_srcaddr  in  AW  response source address (unused, ignored)
- uhost_resp_data  in  DW  response data
- uhost_resp_ready  out  1  response accepted when valid & ready

Behaviour:
- Command encoding:
  - cmd[4:0] is the opcode: REQ_READ=5'h01, REQ_WRITE=5'h03, RESP_READ=5'h02, RESP_WRITE=5'h04.
  - cmd[7:5] is size; it is driven to 3'd2 (4 bytes).
  - cmd[15:8] is len; it is driven to 0.
  - All other cmd bits are driven to 0.
  - Response checks compare cmd[4:0] only.
- Reset (async assert, sync-deasserted usage assumed by system):
  - State is IDLE.
  - Outputs are 0: uhost_req_valid, uhost_resp_ready, busy, done, error, sum, and the req cmd/dstaddr/data registers.
- FSM states: IDLE, WR_A, WT_A, WR_B, WT_B, RD_C, WT_C, FIN.
  - IDLE: on start, latch op_a/op_b, clear error, go to WR_A. busy=0 only in IDLE.
  - WR_A: req_valid=1, cmd=REQ_WRITE, dstaddr=DEVBASE+0x00, data=A. On req_ready, go to WT_A.
  - WT_A: resp_ready=1. On resp_valid, go to WR_B; set error if opcode != RESP_WRITE.
  - WR_B / WT_B: same as WR_A / WT_A with dstaddr=DEVBASE+0x08 and data=B.
  - RD_C: req_valid=1, cmd=REQ_READ, dstaddr=DEVBASE+0x10, data=0. On req_ready, go to WT_C.
  - WT_C: resp_ready=1. On resp_valid, sum<=resp_data and go to FIN; set error if opcode != RESP_READ.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Request handshake:
  - valid and all payload fields are registered and held stable until ready.
  - valid never drops without a handshake.
  - valid & ready in the same cycle as valid rises completes the transfer in that cycle.
- Response handshake:
  - resp_ready is registered and asserted only in WT_* states.
  - A response arriving in other states is not accepted (back-pressured).
- Only one outstanding request; no pipelining. Minimum latency start→done is 7 cycles with ready/resp returned immediately.
- The error flag is sticky across a transaction and cleared by the next accepted start. An error does not abort the sequence.
- start while busy is ignored. Address arithmetic wraps modulo 2^AW.

Optional Feature:
- Macro: UMI_ADDER_HOST_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter resets on entry to each WT_* state and counts while waiting.
  - Reaching 16'hFFFF forces error=1 and goes to FIN (done pulses); remaining steps are skipped and sum is unchanged.
  - A response arriving in that same cycle takes priority (normal completion).
- Disabled: no counter; WT_* states wait indefinitely.

Test Plan:
1. Basic: reset, start with op_a=5 and op_b=7, device answers with zero wait. Expect writes 5@0x00 and 7@0x08, then a read at 0x10; device returns 12; done with sum=12, error=0; done arrives 7 cycles after start.
2. Back-pressure: hold req_ready=0 for 3 cycles on each request. Expect valid held and cmd/dstaddr/data stable throughout, exactly 3 requests total, sum correct.
3. Wrong response: return RESP_READ (5'h02) for the first write ack. Expect the sequence to complete, done with error=1; the next start with 1+1 yields sum=2 and error=0.
4. Busy/start: pulse start again mid-transaction with op_a=9. Expect it ignored, sum from the first operands, busy=1 until FIN.
5. Reset mid-operation: assert nreset low during WT_B. Expect all outputs 0 immediately (asynchronous) and state IDLE; a new start works normally.
6. Timeout (UMI_ADDER_HOST_TIMEOUT_EN): never return a response to the read. Expect done with error=1 after 65535 wait cycles in WT_C, and sum unchanged.
